// File: rtl/tlb_flush_sequencer_pkg.sv
// Shared types for the TLB flush sequencer.
// State encoding used by the full-invalidate control FSM.
package cva5_types;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    CLEAR  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } tlb_flush_state_t;

endpackage

// File: rtl/tlb_flush_sequencer.sv
// Sequences a full TLB invalidation: drain lookups, clear every entry, settle, pulse done.
// Requests arriving while busy coalesce into one extra full flush.
module tlb_flush_sequencer
  import cva5_types::*;
#(
  parameter int ENTRIES       = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_req,
  input  logic                       lookup_inflight,
  output logic                       lookup_block,
  output logic                       clear_en,
  output logic [$clog2(ENTRIES)-1:0] clear_index,
  output logic                       busy,
  output logic                       flush_done
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  tlb_flush_state_t state_r, state_s;
  logic [IDX_W-1:0] index_r, index_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             pending_r, pending_s;

  // State, index, settle counter and pending-request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      index_r   <= '0;
      count_r   <= '0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      index_r   <= index_s;
      count_r   <= count_s;
      pending_r <= pending_s;
    end
  end

  // Next-state, index walk, settle countdown and request coalescing
  always_comb begin
    state_s   = state_r;
    index_s   = index_r;
    count_s   = count_r;
    pending_s = pending_r;
    case (state_r)
      IDLE: begin
        if (flush_req || pending_r) begin
          state_s   = DRAIN;
          pending_s = 1'b0;
        end else begin
          state_s   = IDLE;
        end
      end
      DRAIN: begin
        pending_s = pending_r | flush_req;
        if (!lookup_inflight) begin
          state_s = CLEAR;
          index_s = '0;
        end else begin
          state_s = DRAIN;
        end
      end
      CLEAR: begin
        pending_s = pending_r | flush_req;
        if (index_r == LAST_IDX) begin
          state_s = SETTLE;
          count_s = SETTLE_LOAD;
        end else begin
          index_s = index_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      SETTLE: begin
        pending_s = pending_r | flush_req;
        if (count_r == '0) begin
          state_s = DONE;
        end else begin
          count_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        // A request landing in DONE chains straight into the next drain
        if (flush_req || pending_r) begin
          state_s   = DRAIN;
          pending_s = 1'b0;
        end else begin
          state_s   = IDLE;
        end
      end
      default: begin
        state_s   = IDLE;
        index_s   = '0;
        count_s   = '0;
        pending_s = 1'b0;
      end
    endcase
  end

  // Outputs registered from the upcoming state so they never see inputs combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookup_block <= 1'b0;
      busy         <= 1'b0;
      clear_en     <= 1'b0;
      clear_index  <= '0;
      flush_done   <= 1'b0;
    end else begin
      lookup_block <= (state_s != IDLE);
      busy         <= (state_s != IDLE);
      clear_en     <= (state_s == CLEAR);
      clear_index  <= (state_s == CLEAR) ? index_s : '0;
      flush_done   <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_tlb_flush_sequencer.sv
// Self-checking bench: default and minimal (2 entries, 1 settle) instances against a
// positional reference model, with directed latency scenarios and random traffic.
module tb_tlb_flush_sequencer;

  localparam int ENT [2] = '{16, 2};
  localparam int SET [2] = '{4, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_req = 1'b0;
  logic lookup_inflight = 1'b0;

  logic       a_blk, a_clr, a_busy, a_done;
  logic [3:0] a_idx;
  logic       b_blk, b_clr, b_busy, b_done;
  logic [0:0] b_idx;

  tlb_flush_sequencer #(.ENTRIES(16), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .flush_req(flush_req), .lookup_inflight(lookup_inflight),
    .lookup_block(a_blk), .clear_en(a_clr), .clear_index(a_idx), .busy(a_busy),
    .flush_done(a_done)
  );

  tlb_flush_sequencer #(.ENTRIES(2), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .flush_req(flush_req), .lookup_inflight(lookup_inflight),
    .lookup_block(b_blk), .clear_en(b_clr), .clear_index(b_idx), .busy(b_busy),
    .flush_done(b_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  bit rec      = 1'b0;

  // Reference model: a flush is "draining" until inflight clears, then walks positions
  // 0..E-1 (clears), E..E+S-1 (settle), E+S (done).
  bit m_active [2];
  bit m_drain  [2];
  bit m_pend   [2];
  int m_pos    [2];

  // Per-scenario observations
  int a_done_q[$];
  int b_done_q[$];
  int a_clr_cnt, b_clr_cnt, a_first_clr, b_first_clr, a_last_busy, a_busy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_active[k] <= 1'b0;
        m_drain[k]  <= 1'b0;
        m_pend[k]   <= 1'b0;
        m_pos[k]    <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_active[k]) begin
          if (flush_req || m_pend[k]) begin
            m_active[k] <= 1'b1;
            m_drain[k]  <= 1'b1;
            m_pend[k]   <= 1'b0;
          end
        end else if (m_drain[k]) begin
          if (flush_req) m_pend[k] <= 1'b1;
          if (!lookup_inflight) begin
            m_drain[k] <= 1'b0;
            m_pos[k]   <= 0;
          end
        end else if (m_pos[k] == ENT[k] + SET[k]) begin
          if (flush_req || m_pend[k]) begin
            m_drain[k] <= 1'b1;
            m_pend[k]  <= 1'b0;
          end else begin
            m_active[k] <= 1'b0;
          end
        end else begin
          m_pos[k] <= m_pos[k] + 1;
          if (flush_req) m_pend[k] <= 1'b1;
        end
      end
    end
  end

  task automatic compare_one(input int k, input logic blk, input logic clr, input int idx,
                             input logic bsy, input logic dn);
    logic e_clr, e_done;
    int   e_idx;
    string p;
    p      = (k == 0) ? "a." : "b.";
    e_clr  = m_active[k] && !m_drain[k] && (m_pos[k] < ENT[k]);
    e_done = m_active[k] && !m_drain[k] && (m_pos[k] == ENT[k] + SET[k]);
    e_idx  = e_clr ? m_pos[k] : 0;
    check_eq({p, "lookup_block"}, 32'(blk), 32'(m_active[k]));
    check_eq({p, "busy"}, 32'(bsy), 32'(m_active[k]));
    check_eq({p, "clear_en"}, 32'(clr), 32'(e_clr));
    check_eq({p, "clear_index"}, 32'(idx), 32'(e_idx));
    check_eq({p, "flush_done"}, 32'(dn), 32'(e_done));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_one(0, a_blk, a_clr, int'(a_idx), a_busy, a_done);
    compare_one(1, b_blk, b_clr, int'(b_idx), b_busy, b_done);
    if (rec) begin
      if (a_clr) begin
        if (a_clr_cnt == 0) a_first_clr = cyc - base;
        a_clr_cnt++;
      end
      if (b_clr) begin
        if (b_clr_cnt == 0) b_first_clr = cyc - base;
        b_clr_cnt++;
      end
      if (a_done) a_done_q.push_back(cyc - base);
      if (b_done) b_done_q.push_back(cyc - base);
      if (a_busy) begin
        a_last_busy = cyc - base;
        a_busy_cnt++;
      end
    end
  endtask

  task automatic clear_obs();
    a_done_q.delete();
    b_done_q.delete();
    a_clr_cnt = 0; b_clr_cnt = 0; a_first_clr = -1; b_first_clr = -1;
    a_last_busy = -1; a_busy_cnt = 0;
  endtask

  task automatic scenario(input int reqs[$], input int infl_until, input int ncyc);
    clear_obs();
    rec = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (c == 0) begin
        base = cyc;
        rec  = 1'b1;
      end
      flush_req = 1'b0;
      foreach (reqs[i]) if (reqs[i] == c) flush_req = 1'b1;
      lookup_inflight = (c <= infl_until);
    end
    flush_req       = 1'b0;
    lookup_inflight = 1'b0;
    rec             = 1'b0;
  endtask

  initial begin
    bit found;
    clear_obs();
    tick();
    check_eq("reset.busy", 32'(a_busy), 32'd0);
    check_eq("reset.clear_index", 32'(a_idx), 32'd0);
    rst = 1'b1;
    tick();

    // Basic flush
    scenario('{0}, -1, 30);
    check_eq("basic.first_clear", a_first_clr, 32'd2);
    check_eq("basic.clear_count", a_clr_cnt, 32'd16);
    check_eq("basic.done_count", a_done_q.size(), 32'd1);
    if (a_done_q.size() > 0) check_eq("basic.done_cycle", a_done_q[0], 32'd22);
    check_eq("basic.last_busy", a_last_busy, 32'd22);
    check_eq("small.first_clear", b_first_clr, 32'd2);
    check_eq("small.clear_count", b_clr_cnt, 32'd2);
    if (b_done_q.size() > 0) check_eq("small.done_cycle", b_done_q[0], 32'd5);
    else check_eq("small.done_count", 32'd0, 32'd1);

    // Drain stall
    scenario('{0}, 9, 40);
    check_eq("drain.first_clear", a_first_clr, 32'd11);
    if (a_done_q.size() > 0) check_eq("drain.done_cycle", a_done_q[0], 32'd31);
    else check_eq("drain.done_count", 32'd0, 32'd1);

    // Coalescing
    scenario('{0, 5, 7, 20}, -1, 55);
    check_eq("coalesce.clear_count", a_clr_cnt, 32'd32);
    check_eq("coalesce.done_count", a_done_q.size(), 32'd2);
    if (a_done_q.size() == 2) begin
      check_eq("coalesce.done0", a_done_q[0], 32'd22);
      check_eq("coalesce.done1", a_done_q[1], 32'd44);
    end
    check_eq("coalesce.no_idle_gap", a_busy_cnt, 32'd44);

    // Request in the DONE cycle
    scenario('{0, 22}, -1, 55);
    check_eq("in_done.done_count", a_done_q.size(), 32'd2);
    if (a_done_q.size() == 2) check_eq("in_done.done1", a_done_q[1], 32'd44);
    check_eq("in_done.busy_cycles", a_busy_cnt, 32'd44);

    // Async reset mid-CLEAR
    clear_obs();
    tick();
    base = cyc;
    rec = 1'b1;
    flush_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      flush_req = 1'b0;
      if (a_clr && a_idx == 4'd7) found = 1'b1;
    end
    check_eq("rst_mid.reached_index7", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_mid.lookup_block", 32'(a_blk), 32'd0);
    check_eq("rst_mid.clear_en", 32'(a_clr), 32'd0);
    check_eq("rst_mid.clear_index", 32'(a_idx), 32'd0);
    check_eq("rst_mid.busy", 32'(a_busy), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    check_eq("rst_mid.no_done", a_done_q.size(), 32'd0);
    rec = 1'b0;
    scenario('{}, -1, 6);
    check_eq("rst_mid.pending_lost", a_busy_cnt, 32'd0);
    scenario('{0}, -1, 30);
    check_eq("after_rst.first_clear", a_first_clr, 32'd2);
    check_eq("after_rst.clear_count", a_clr_cnt, 32'd16);
    if (a_done_q.size() > 0) check_eq("after_rst.done_cycle", a_done_q[0], 32'd22);
    else check_eq("after_rst.done_count", 32'd0, 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      tick();
      flush_req       = ($urandom_range(0, 7) == 0);
      lookup_inflight = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 199) != 0);
    end
    rst = 1'b1;
    flush_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
